// File: rtl/wb_stage_mlane.sv
// Multi-lane writeback stage: register-file write ports, id bypass bus and compacting trace FIFO.
// Optional macro WB_TRACE_EN builds the trace FIFO and debug port; without it the debug port is tied to 0.
module wb_stage_mlane #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_to_wb_valid,
  input  logic [LANES-1:0]      mem_to_wb_lane_v,
  input  logic [70*LANES-1:0]   mem_to_wb_bus,
  output logic                  wb_allowin,
  output logic [39*LANES-1:0]   wb_to_id_bus,
  output logic [LANES-1:0]      rf_we,
  output logic [5*LANES-1:0]    rf_waddr,
  output logic [32*LANES-1:0]   rf_wdata,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  logic                  wb_valid;
  logic [LANES-1:0]      wb_lane_v;
  logic [70*LANES-1:0]   wb_data;
  logic                  wb_ready_go;
  logic                  retire;
  logic [LANES-1:0]      lane_regw;
  logic [4:0]            lane_waddr [LANES];
  logic [31:0]           lane_wdata [LANES];

  assign wb_allowin = ~wb_valid | wb_ready_go;
  assign retire     = wb_valid & wb_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (wb_allowin) begin
      wb_valid <= mem_to_wb_valid;
    end
  end

  // Payload registers carry no reset; they are only observed while wb_valid is set.
  always_ff @(posedge clk) begin
    if (wb_allowin && mem_to_wb_valid) begin
      wb_lane_v <= mem_to_wb_lane_v;
      wb_data   <= mem_to_wb_bus;
    end
  end

  always_comb begin
    rf_we        = '0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    wb_to_id_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_regw[i]  = wb_data[70*i+69];
      lane_waddr[i] = wb_data[70*i+64 +: 5];
      lane_wdata[i] = wb_data[70*i+32 +: 32];
      rf_we[i]              = retire & wb_lane_v[i] & lane_regw[i];
      rf_waddr[5*i +: 5]    = lane_waddr[i];
      rf_wdata[32*i +: 32]  = lane_wdata[i];
      // Bypass lane stays valid while stalled so id still sees the pending write.
      wb_to_id_bus[39*i +: 39] = {wb_valid & wb_lane_v[i], lane_regw[i], lane_waddr[i], lane_wdata[i]};
    end
  end

`ifdef WB_TRACE_EN
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] lane_cnt;
  logic [CW-1:0] need;
  logic [CW-1:0] free;
  logic [CW-1:0] push_n;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          pop;
  logic [PW-1:0] slot [LANES];

  logic [31:0]   fifo_pc    [DEPTH];
  logic          fifo_regw  [DEPTH];
  logic [4:0]    fifo_wnum  [DEPTH];
  logic [31:0]   fifo_wdata [DEPTH];

  // Explicit wrap so non-power-of-2 depths work; base + off never reaches 2*DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input logic [CW-1:0] off);
    int s;
    s = int'(base) + int'(off);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = ptr_add(tail, lane_cnt);
      if (wb_lane_v[i]) lane_cnt = lane_cnt + CW'(1);
    end
  end

  assign need        = wb_valid ? lane_cnt : '0;
  assign pop         = (count != '0);
  assign free        = CW'(DEPTH) - count + CW'(pop);
  assign wb_ready_go = (need <= free);
  assign push_n      = retire ? need : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= ptr_add(head, CW'(1));
      tail  <= ptr_add(tail, push_n);
      count <= count + push_n - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (retire) begin
      for (int i = 0; i < LANES; i++) begin
        if (wb_lane_v[i]) begin
          fifo_pc[slot[i]]    <= wb_data[70*i +: 32];
          fifo_regw[slot[i]]  <= lane_regw[i];
          fifo_wnum[slot[i]]  <= lane_waddr[i];
          fifo_wdata[slot[i]] <= lane_wdata[i];
        end
      end
    end
  end

  assign debug_wb_pc       = pop ? fifo_pc[head] : '0;
  assign debug_wb_rf_wen   = pop ? {4{fifo_regw[head]}} : 4'h0;
  assign debug_wb_rf_wnum  = pop ? fifo_wnum[head] : '0;
  assign debug_wb_rf_wdata = pop ? fifo_wdata[head] : '0;
`else
  logic unused_trace;

  // pc fields only feed the trace record, which this build omits.
  assign unused_trace      = ^{wb_data, 32'(DEPTH)};
  assign wb_ready_go       = 1'b1;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = 4'h0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule
